xs3_word_deserializer: RTL and testbench

Downstream stage of the serial BCD-to-Excess-3 converter. Consumes the converter's LSB-first serial Excess-3 stream (its S output) and regroups it into 4-bit codes. Range-checks each code, converts it back to BCD, and assembles NDIG digits into one parallel word. Presents the word to a parallel consumer through a valid/ack handshake, with overflow reporting.

---
 rtl/xs3_pkg.sv | 23 ++
 rtl/xs3_digit_check.sv | 25 ++
 rtl/xs3_word_deserializer.sv | 167 ++++++++++++++++
 tb/tb_xs3_word_deserializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xs3_pkg
//  Description : Constants and types shared by the Excess-3 serial converter
//                and its downstream word deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package xs3_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_MIN     = 4'd3;
    localparam logic [3:0] XS3_MAX     = 4'd12;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Occupancy of the parallel output register.
    typedef enum logic [0:0] {
        WV_EMPTY = 1'b0,
        WV_FULL  = 1'b1
    } wv_state_t;

endpackage : xs3_pkg
`default_nettype wire

// File: rtl/xs3_digit_check.sv
`default_nettype none
// ============================================================================
//  Module      : xs3_digit_check
//  Description : Combinational range check and Excess-3 to BCD conversion of
//                one 4-bit code. Out-of-range codes map to BCD_INVALID.
//  Revision    : 1.0 - initial release
//  Ports       : code    - Excess-3 code in
//                bcd     - BCD digit out (BCD_INVALID when code is invalid)
//                invalid - code lies outside XS3_MIN..XS3_MAX
// ============================================================================
module xs3_digit_check
    import xs3_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [DIGIT_W-1:0] bcd,
    output logic               invalid
);

    always_comb begin
        invalid = (code < XS3_MIN) || (code > XS3_MAX);
        bcd     = invalid ? BCD_INVALID : (code - XS3_OFFSET);
    end

endmodule : xs3_digit_check
`default_nettype wire

// File: rtl/xs3_word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : xs3_word_deserializer
//  Description : Regroups an LSB-first serial Excess-3 stream into 4-bit
//                codes, converts each to BCD and assembles NDIG digits into a
//                parallel word offered through a valid/ack handshake.
//                All state updates on the falling edge of CLK.
//  Revision    : 1.0 - initial release
//  Ports       : CLK    - clock (falling edge active)
//                Clr    - asynchronous active-high clear
//                S_in   - serial Excess-3 bit, LSB of each digit first
//                En     - bit-valid qualifier
//                Ack    - consumer accepts the current word
//                Word   - BCD word, digit 0 (first received) in [3:0]
//                WValid - Word holds an unacknowledged word
//                WErr   - held word contains an invalid code
//                Ovf    - sticky: a completed word was dropped
//                BitCnt - bit position of the next bit within the digit
// ============================================================================
module xs3_word_deserializer
    import xs3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    CLK,
    input  logic                    Clr,
    input  logic                    S_in,
    input  logic                    En,
    input  logic                    Ack,
    output logic [NDIG*DIGIT_W-1:0] Word,
    output logic                    WValid,
    output logic                    WErr,
    output logic                    Ovf,
    output logic [1:0]              BitCnt
);

    localparam int            WORD_W = NDIG * DIGIT_W;
    localparam int            DCNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DCNT_W-1:0] DIG_LAST = DCNT_W'(NDIG - 1);

    // Only the upper three bits of the 4-bit shift register are ever read
    // (the incoming bit supplies the fourth), so the LSB is not stored.
    logic [DIGIT_W-2:0] sh;
    logic [1:0]         bit_cnt;
    logic [DCNT_W-1:0]  dig_cnt;
    logic [WORD_W-1:0]  staging;
    logic               err_acc;
    logic [WORD_W-1:0]  word_q;
    logic               werr_q;
    logic               ovf_q;

    wv_state_t          state;
    wv_state_t          state_nxt;
    logic               load_word;
    logic               drop_word;

    logic [DIGIT_W-1:0] code;
    logic [DIGIT_W-1:0] dig_bcd;
    logic               dig_invalid;
    logic               digit_done;
    logic               word_done;
    logic [WORD_W-1:0]  staging_nxt;
    logic               err_nxt;

    assign code       = {S_in, sh};
    assign digit_done = En && (bit_cnt == 2'd3);
    assign word_done  = digit_done && (dig_cnt == DIG_LAST);

    xs3_digit_check u_digit_check (
        .code    (code),
        .bcd     (dig_bcd),
        .invalid (dig_invalid)
    );

    // Staging word and error flag as they stand including the digit that
    // completes on this edge; this is what a completed word delivers.
    always_comb begin
        staging_nxt = staging;
        staging_nxt[dig_cnt*DIGIT_W +: DIGIT_W] = dig_bcd;
        err_nxt = err_acc | dig_invalid;
    end

    // ------------------------------------------------------------------------
    // Output-register occupancy FSM
    // ------------------------------------------------------------------------
    always_ff @(negedge CLK or posedge Clr) begin
        if (Clr) begin
            state <= WV_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        drop_word = 1'b0;
        case (state)
            WV_EMPTY: begin
                if (word_done) begin
                    load_word = 1'b1;
                    state_nxt = WV_FULL;
                end
            end
            WV_FULL: begin
                if (word_done) begin
                    // Ack on the completing edge frees the register in time
                    // for the new word; otherwise the new word is lost.
                    if (Ack) begin
                        load_word = 1'b1;
                    end else begin
                        drop_word = 1'b1;
                    end
                end else if (Ack) begin
                    state_nxt = WV_EMPTY;
                end
            end
            default: state_nxt = WV_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------------
    // Serial collection and word assembly (never stalls)
    // ------------------------------------------------------------------------
    always_ff @(negedge CLK or posedge Clr) begin
        if (Clr) begin
            sh      <= '0;
            bit_cnt <= '0;
            dig_cnt <= '0;
            staging <= '0;
            err_acc <= 1'b0;
            word_q  <= '0;
            werr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (En) begin
                sh      <= code[DIGIT_W-1:1];
                bit_cnt <= bit_cnt + 2'd1;
            end
            if (digit_done) begin
                staging <= staging_nxt;
                if (word_done) begin
                    dig_cnt <= '0;
                    err_acc <= 1'b0;
                end else begin
                    dig_cnt <= dig_cnt + DCNT_W'(1);
                    err_acc <= err_nxt;
                end
            end
            if (load_word) begin
                word_q <= staging_nxt;
                werr_q <= err_nxt;
            end
            if (drop_word) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign Word   = word_q;
    assign WValid = (state == WV_FULL);
    assign WErr   = werr_q;
    assign Ovf    = ovf_q;
    assign BitCnt = bit_cnt;

endmodule : xs3_word_deserializer
`default_nettype wire

// File: tb/tb_xs3_word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xs3_word_deserializer
//  Description : Self-checking bench for xs3_word_deserializer (NDIG=4).
//                Expected words are pushed to a queue as streams are driven
//                and popped when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xs3_word_deserializer;

    localparam int NDIG = 4;

    logic        CLK;
    logic        Clr;
    logic        S_in;
    logic        En;
    logic        Ack;
    logic [15:0] Word;
    logic        WValid;
    logic        WErr;
    logic        Ovf;
    logic [1:0]  BitCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] word;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    xs3_word_deserializer #(.NDIG(NDIG)) dut (
        .CLK    (CLK),
        .Clr    (Clr),
        .S_in   (S_in),
        .En     (En),
        .Ack    (Ack),
        .Word   (Word),
        .WValid (WValid),
        .WErr   (WErr),
        .Ovf    (Ovf),
        .BitCnt (BitCnt)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // Reference Excess-3 decode of a single code.
    function automatic logic [3:0] ref_bcd(input logic [3:0] c);
        if (c >= 4'd3 && c <= 4'd12) return c - 4'd3;
        return 4'hF;
    endfunction

    function automatic exp_t ref_word(input logic [15:0] codes);
        exp_t e;
        logic [3:0] c;
        e.err = 1'b0;
        e.word = '0;
        for (int d = 0; d < 4; d++) begin
            c = codes[d*4 +: 4];
            e.word[d*4 +: 4] = ref_bcd(c);
            if (!(c >= 4'd3 && c <= 4'd12)) e.err = 1'b1;
        end
        return e;
    endfunction

    // Drive 16 bits LSB-first. Ack is raised only on the final bit when
    // requested. A 3-cycle En=0 gap is inserted before bit gap_at (<0: none).
    task automatic send_word(input logic [15:0] codes, input logic ack_last,
                             input int gap_at, input logic expect_load);
        logic [1:0] bc;
        if (expect_load) exp_q.push_back(ref_word(codes));
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge CLK); En = 1'b0; Ack = 1'b0;
                    @(negedge CLK); #1;
                    bc = 2'(i % 4);
                    checks++;
                    if (BitCnt !== bc) begin
                        errors++;
                        $display("FAIL gap_bitcnt: got %0d expected %0d", BitCnt, bc);
                    end
                end
            end
            @(posedge CLK);
            S_in = codes[i];
            En   = 1'b1;
            Ack  = (i == 15) ? ack_last : 1'b0;
            @(negedge CLK); #1;
        end
    endtask

    task automatic idle(input int n, input logic ack);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); En = 1'b0; Ack = ack; S_in = 1'b0;
            @(negedge CLK); #1;
        end
    endtask

    // Pop the next expected word and compare against the presented one.
    task automatic check_presented(input string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (WValid !== 1'b1 || Word !== e.word || WErr !== e.err) begin
            errors++;
            $display("FAIL %s: got Word=%h WValid=%b WErr=%b expected Word=%h WValid=1 WErr=%b",
                     name, Word, WValid, WErr, e.word, e.err);
        end
    endtask

    task automatic ack_word(input string name);
        logic [15:0] held;
        held = Word;
        idle(1, 1'b1);
        idle(1, 1'b0);
        checks++;
        if (WValid !== 1'b0 || Word !== held) begin
            errors++;
            $display("FAIL %s_ack: got WValid=%b Word=%h expected WValid=0 Word=%h",
                     name, WValid, Word, held);
        end
    endtask

    task automatic test_reset();
        Clr = 1'b1; S_in = 1'b0; En = 1'b0; Ack = 1'b0;
        #3;
        checks++;
        if (Word !== 16'h0 || WValid !== 1'b0 || WErr !== 1'b0 || Ovf !== 1'b0 || BitCnt !== 2'd0) begin
            errors++;
            $display("FAIL reset: got Word=%h WValid=%b WErr=%b Ovf=%b BitCnt=%0d expected all 0",
                     Word, WValid, WErr, Ovf, BitCnt);
        end
        @(posedge CLK); #1 Clr = 1'b0;
    endtask

    task automatic test_basic();
        send_word(16'h7654, 1'b0, -1, 1'b1);
        check_presented("basic");
        checks++;
        if (Ovf !== 1'b0 || BitCnt !== 2'd0) begin
            errors++;
            $display("FAIL basic_flags: got Ovf=%b BitCnt=%0d expected 0 0", Ovf, BitCnt);
        end
        ack_word("basic");
        // Ack with nothing held must be ignored.
        idle(2, 1'b1);
        checks++;
        if (WValid !== 1'b0 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: got WValid=%b Ovf=%b expected 0 0", WValid, Ovf);
        end
    endtask

    task automatic test_invalid();
        send_word(16'h7F54, 1'b0, -1, 1'b1);
        check_presented("invalid_F");
        ack_word("invalid_F");
        send_word(16'h7054, 1'b0, -1, 1'b1);
        check_presented("invalid_0");
        ack_word("invalid_0");
        // Codes 2 and 13 sit just outside the valid range.
        send_word(16'hD254, 1'b0, -1, 1'b1);
        check_presented("invalid_edge");
        ack_word("invalid_edge");
        send_word(16'h7654, 1'b0, -1, 1'b1);
        check_presented("clean_after_err");
        ack_word("clean_after_err");
    endtask

    task automatic test_gap();
        send_word(16'h7654, 1'b0, 2, 1'b1);
        check_presented("gap");
        ack_word("gap");
    endtask

    task automatic test_back_to_back();
        exp_t a;
        // Drop: B completes while A still held, no Ack.
        send_word(16'hBBBB, 1'b0, -1, 1'b1);
        a = exp_q[0];
        checks++;
        if (Word !== a.word || WValid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_A: got Word=%h WValid=%b expected Word=%h WValid=1", Word, WValid, a.word);
        end
        send_word(16'h4567, 1'b0, -1, 1'b0);
        check_presented("b2b_drop");
        checks++;
        if (Ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ovf: got Ovf=%b expected 1", Ovf);
        end
        idle(3, 1'b0);
        checks++;
        if (Ovf !== 1'b1 || WValid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got Ovf=%b WValid=%b expected 1 1", Ovf, WValid);
        end
        @(posedge CLK); #1 Clr = 1'b1; #1 Clr = 1'b0;
        // Reload: Ack on B's final edge lets B replace A.
        send_word(16'hBBBB, 1'b0, -1, 1'b0);
        send_word(16'h4567, 1'b1, -1, 1'b1);
        check_presented("b2b_reload");
        checks++;
        if (Ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload_ovf: got Ovf=%b expected 0", Ovf);
        end
        ack_word("b2b_reload");
    endtask

    task automatic test_clear_mid();
        logic [15:0] junk;
        junk = 16'h9999;
        send_word(16'h5678, 1'b0, -1, 1'b1);
        check_presented("pre_clear");
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK); S_in = junk[i]; En = 1'b1; Ack = 1'b0;
            @(negedge CLK); #1;
        end
        @(posedge CLK); En = 1'b0;
        #2 Clr = 1'b1;
        #1;
        checks++;
        if (Word !== 16'h0 || WValid !== 1'b0 || WErr !== 1'b0 || Ovf !== 1'b0 || BitCnt !== 2'd0) begin
            errors++;
            $display("FAIL clear_mid: got Word=%h WValid=%b WErr=%b Ovf=%b BitCnt=%0d expected all 0",
                     Word, WValid, WErr, Ovf, BitCnt);
        end
        #1 Clr = 1'b0;
        send_word(16'h7654, 1'b0, -1, 1'b1);
        check_presented("after_clear");
        ack_word("after_clear");
    endtask

    task automatic test_end_to_end();
        logic [3:0]  digits [4];
        logic [15:0] codes;
        digits = '{4'd9, 4'd0, 4'd5, 4'd7};
        // Upstream converter: each BCD digit becomes digit+3, LSB first.
        for (int d = 0; d < 4; d++) codes[d*4 +: 4] = digits[d] + 4'd3;
        send_word(codes, 1'b0, -1, 1'b1);
        checks++;
        if (Word !== 16'h7509 || WErr !== 1'b0) begin
            errors++;
            $display("FAIL end_to_end: got Word=%h WErr=%b expected 7509 0", Word, WErr);
        end
        check_presented("end_to_end_sb");
        ack_word("end_to_end");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_gap();
        test_back_to_back();
        test_clear_mid();
        test_end_to_end();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected words never presented", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_xs3_word_deserializer
`default_nettype wire
